// File: rtl/yarp_pkg.sv
// Shared access-size encoding, MMIO register map and small decode helpers
// for the yarp data-memory controller.
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b11
  } access_size_e;

  localparam logic [31:0] TX_DATA_OFF = 32'h0;
  localparam logic [31:0] STATUS_OFF  = 32'h4;
  localparam logic [31:0] CYCLES_OFF  = 32'h8;

  // The reserved size encoding is reported as misaligned so it shares the error path.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] lsb);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return lsb[0];
      WORD:    return lsb != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(logic [1:0] size, logic [1:0] lsb);
    case (size)
      BYTE:    return 4'b0001 << lsb;
      HALF:    return 4'b0011 << lsb;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/yarp_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while
// empty are ignored here, the owner decides how to report them.
module yarp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = count == CW'(DEPTH);
  assign empty    = count == '0;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left unreset; pointers and count alone
  // define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/yarp_dmem_ctrl.sv
// Data-memory controller: zero-wait RAM, TX byte FIFO, status and cycle
// counter registers, with a sticky error flag for illegal accesses.
module yarp_dmem_ctrl
  import yarp_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_2000,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int          TX_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_mem_req_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [1:0]  data_mem_byte_en_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_wr_data_i,
  output logic [31:0] data_mem_rd_data_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        err_o
);

  localparam int          RAM_AW    = $clog2(DMEM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DMEM_WORDS);
  localparam int          CNT_W     = $clog2(TX_DEPTH + 1);

  logic [31:0]       ram [DMEM_WORDS];
  logic [31:0]       ram_offset;
  logic [RAM_AW-1:0] word_idx;
  logic              in_ram;
  logic              sel_tx;
  logic              sel_status;
  logic              sel_cycles;
  logic              mmio_hit;
  logic              access_err;
  logic              access_ok;
  logic              ram_we;
  logic [3:0]        wr_mask;
  logic [31:0]       wr_lanes;
  logic [31:0]       ram_word;
  logic [31:0]       ram_shifted;
  logic [31:0]       ram_load;
  logic [31:0]       status_word;
  logic [31:0]       cycle_cnt;
  logic              cycle_clear;
  logic              err_q;
  logic              overflow_q;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  // Address decode; the offset subtraction folds the lower/upper RAM bound
  // checks into one unsigned compare.
  always_comb begin
    ram_offset = data_mem_addr_i - DMEM_BASE;
    in_ram     = ram_offset < RAM_BYTES;
    sel_tx     = data_mem_addr_i == (MMIO_BASE + TX_DATA_OFF);
    sel_status = data_mem_addr_i == (MMIO_BASE + STATUS_OFF);
    sel_cycles = data_mem_addr_i == (MMIO_BASE + CYCLES_OFF);
    mmio_hit   = sel_tx || sel_status || sel_cycles;
    access_err = data_mem_req_i &&
                 (is_misaligned(data_mem_byte_en_i, data_mem_addr_i[1:0]) ||
                  !(in_ram || mmio_hit) ||
                  (mmio_hit && data_mem_byte_en_i != WORD));
    access_ok  = data_mem_req_i && !access_err;
  end

  assign word_idx    = data_mem_addr_i[RAM_AW+1:2];
  assign wr_mask     = lane_mask(data_mem_byte_en_i, data_mem_addr_i[1:0]);
  assign ram_we      = access_ok && data_mem_wr_i && in_ram && !reset;
  assign fifo_push   = access_ok && data_mem_wr_i && sel_tx;
  assign cycle_clear = access_ok && data_mem_wr_i && sel_cycles;

  // Replicating the low byte/half onto every lane lets the mask pick the target lane.
  always_comb begin
    case (data_mem_byte_en_i)
      BYTE:    wr_lanes = {4{data_mem_wr_data_i[7:0]}};
      HALF:    wr_lanes = {2{data_mem_wr_data_i[15:0]}};
      default: wr_lanes = data_mem_wr_data_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) ram[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  assign ram_word    = ram[word_idx];
  assign ram_shifted = ram_word >> {data_mem_addr_i[1:0], 3'b000};

  always_comb begin
    case (data_mem_byte_en_i)
      BYTE:    ram_load = ram_shifted & 32'h0000_00FF;
      HALF:    ram_load = ram_shifted & 32'h0000_FFFF;
      default: ram_load = ram_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt  <= '0;
      err_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cycle_cnt <= cycle_clear ? 32'h0 : cycle_cnt + 32'd1;
      if (access_err)             err_q      <= 1'b1;
      if (fifo_push && fifo_full) overflow_q <= 1'b1;
    end
  end

  yarp_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (data_mem_wr_data_i[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Outputs are forced low while reset is held so they are clean in that cycle too.
  assign tx_valid_o = !fifo_empty && !reset;
  assign tx_data_o  = tx_valid_o ? fifo_head : 8'h00;
  assign fifo_pop   = tx_valid_o && tx_ready_i;
  assign err_o      = err_q && !reset;

  assign status_word = {26'b0, overflow_q, 3'(fifo_count), fifo_empty, fifo_full};

  // NOTE: the default assignment up front keeps this mux free of inferred latches.
  always_comb begin
    data_mem_rd_data_o = 32'h0;
    if (access_ok && !data_mem_wr_i) begin
      if (in_ram)          data_mem_rd_data_o = ram_load;
      else if (sel_status) data_mem_rd_data_o = status_word;
      else if (sel_cycles) data_mem_rd_data_o = cycle_cnt;
    end
  end

endmodule
